// File: rtl/sha256_msg_pad_if.sv
// Handshake bundle between the message source, the padder and the sha256 core.
// slave = the padder's view; master = the environment driving it.
interface sha256_msg_pad_if;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  in_data;
    logic        in_last;
    logic        buf_data_vld;
    logic        buf_data_rdy;
    logic [31:0] buf_data;
    logic        buf_data_blk_last;
    logic        buf_data_msg_last;

    // Transfer on either side happens on a rising clk edge when vld & rdy are
    // both high; vld is never withdrawn and its payload stays stable until then.
    modport slave (
        input  in_vld, in_data, in_last, buf_data_rdy,
        output in_rdy, buf_data_vld, buf_data, buf_data_blk_last, buf_data_msg_last
    );

    modport master (
        output in_vld, in_data, in_last, buf_data_rdy,
        input  in_rdy, buf_data_vld, buf_data, buf_data_blk_last, buf_data_msg_last
    );
endinterface

// File: rtl/sha256_msg_pad.sv
// Byte-stream to sha256 word-stream packer with FIPS 180-4 padding
// (0x80, zero fill to index 13 of a block, then the 64-bit bit length).
module sha256_msg_pad #(
    parameter int LEN_W = 61
) (
    input  logic             clk,
    input  logic             rst_n,
    sha256_msg_pad_if.slave  bus,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_DATA  = 3'd0,
        S_PAD80 = 3'd1,
        S_ZERO  = 3'd2,
        S_LENHI = 3'd3,
        S_LENLO = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [3:0]         widx_q, widx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [23:0]        asm_q, asm_d;
    logic               ovld_q, ovld_d;
    logic [31:0]        odata_q, odata_d;
    logic               oblk_q, oblk_d;
    logic               omsg_q, omsg_d;
    logic               busy_q, busy_d;
    logic               en_q;

    logic               xfer;
    logic               can_load;
    logic [3:0]         load_idx;
    logic [63:0]        bitlen;
    logic               in_rdy_w;
    logic               in_acc;
    logic               load;
    logic [31:0]        load_word;
    logic               load_msg;
    logic [7:0]         pad_b;

    // load_idx is the block position the next loaded word will occupy: the
    // current widx if the register is empty, one further if it drains now.
    always_comb begin
        xfer      = ovld_q & bus.buf_data_rdy;
        can_load  = !ovld_q | bus.buf_data_rdy;
        load_idx  = widx_q + {3'b000, xfer};
        bitlen    = 64'(cnt_q) << 3;
        in_rdy_w  = en_q & (state_q == S_DATA) & can_load;
        in_acc    = bus.in_vld & in_rdy_w;
        pad_b     = bus.in_last ? 8'h80 : 8'h00;

        state_d   = state_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        busy_d    = busy_q;
        widx_d    = xfer ? widx_q + 4'd1 : widx_q;
        ovld_d    = xfer ? 1'b0 : ovld_q;
        odata_d   = odata_q;
        oblk_d    = xfer ? 1'b0 : oblk_q;
        omsg_d    = xfer ? 1'b0 : omsg_q;
        load      = 1'b0;
        load_word = 32'h0;
        load_msg  = 1'b0;

        case (state_q)
            S_DATA: begin
                if (in_acc) begin
                    busy_d = 1'b1;
                    cnt_d  = cnt_q + LEN_W'(1);
                    case (lane_q)
                        2'd0: begin
                            asm_d[23:16] = bus.in_data;
                            load_word    = {bus.in_data, 8'h80, 16'h0000};
                        end
                        2'd1: begin
                            asm_d[15:8] = bus.in_data;
                            load_word   = {asm_q[23:16], bus.in_data, pad_b, 8'h00};
                        end
                        2'd2: begin
                            asm_d[7:0] = bus.in_data;
                            load_word  = {asm_q[23:8], bus.in_data, pad_b};
                        end
                        default: load_word = {asm_q, bus.in_data};
                    endcase
                    if (lane_q == 2'd3 || bus.in_last) begin
                        load   = 1'b1;
                        lane_d = 2'd0;
                        asm_d  = 24'h0;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                    if (bus.in_last) begin
                        if (lane_q == 2'd3)
                            state_d = S_PAD80;
                        else if (load_idx == 4'd13)
                            state_d = S_LENHI;
                        else
                            state_d = S_ZERO;
                    end
                end
            end
            S_PAD80: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = 32'h8000_0000;
                    state_d   = (load_idx == 4'd13) ? S_LENHI : S_ZERO;
                end
            end
            S_ZERO: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = 32'h0;
                    if (load_idx == 4'd13)
                        state_d = S_LENHI;
                end
            end
            S_LENHI: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = bitlen[63:32];
                    state_d   = S_LENLO;
                end
            end
            S_LENLO: begin
                // Stay here until the final word itself is taken, so in_rdy
                // remains low for the whole drain.
                if (omsg_q) begin
                    if (xfer) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        widx_d  = 4'd0;
                        lane_d  = 2'd0;
                        busy_d  = 1'b0;
                    end
                end else if (can_load) begin
                    load      = 1'b1;
                    load_word = bitlen[31:0];
                    load_msg  = 1'b1;
                end
            end
            default: state_d = S_DATA;
        endcase

        if (load) begin
            ovld_d  = 1'b1;
            odata_d = load_word;
            oblk_d  = (load_idx == 4'd15);
            omsg_d  = load_msg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DATA;
            lane_q  <= 2'd0;
            widx_q  <= 4'd0;
            cnt_q   <= '0;
            asm_q   <= 24'h0;
            ovld_q  <= 1'b0;
            odata_q <= 32'h0;
            oblk_q  <= 1'b0;
            omsg_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            widx_q  <= widx_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ovld_q  <= ovld_d;
            odata_q <= odata_d;
            oblk_q  <= oblk_d;
            omsg_q  <= omsg_d;
            busy_q  <= busy_d;
            en_q    <= 1'b1;
        end
    end

    assign bus.in_rdy            = in_rdy_w;
    assign bus.buf_data_vld      = ovld_q;
    assign bus.buf_data          = odata_q;
    assign bus.buf_data_blk_last = oblk_q;
    assign bus.buf_data_msg_last = omsg_q;
    assign busy                  = busy_q;
    assign dbg_state             = state_q;

endmodule

// File: doc/sha256_msg_pad.md
Name: sha256_msg_pad

Overview:
Transmit side of the sha256 `buf_data` word stream. Accepts a raw message as a byte stream and packs it big-endian into 32-bit words. Appends FIPS 180-4 padding: 0x80, zero fill, then the 64-bit message bit length. Drives the result, 16 words per 512-bit block, into the sha256 core's `buf_data_rdy`/`buf_data_vld`/`buf_data` handshake; it sits in snickerbits between the message source and sha256.

Parameters:
LEN_W, 61, width of the internal byte counter; bit length = {count, 3'b000} zero-extended to 64 bits.

Ports:
clk  input  1  single clock.
rst_n  input  1  asynchronous active-low reset.
in_vld  input  1  message byte valid.
in_rdy  output  1  block can accept a byte this cycle.
in_data  input  8  message byte.
in_last  input  1  final byte of message; qualified by in_vld; every message is at least 1 byte.
buf_data_vld  output  1  output word valid.
buf_data_rdy  input  1  sha256 accepts the word.
buf_data  output  32  padded message word, big-endian (first byte in [31:24]).
buf_data_blk_last  output  1  word is index 15 of a 512-bit block.
buf_data_msg_last  output  1  word is the final word of the message (length low word).
busy  output  1  a message is in progress (≥1 byte accepted, final word not yet accepted).

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0; state S_DATA; lane=0, widx=0, byte count=0; output register empty.
- Transfer occurs on each handshake side when vld & rdy are both high at a rising clk edge.
- Output register: single entry; buf_data/blk_last/msg_last hold stable while buf_data_vld=1 and buf_data_rdy=0. The vld may not drop without a transfer.
- widx (4-bit) increments on every output transfer and wraps 15->0. buf_data_blk_last = (widx==15).
- States: S_DATA, S_PAD80, S_ZERO, S_LENHI, S_LENLO.
- S_DATA:
  - in_rdy = !buf_data_vld | buf_data_rdy.
  - An accepted byte goes into assembly lane `lane` (0=[31:24]); lane++ and byte count++.
  - When lane==3, or on in_last, the assembled word is loaded into the output register on the same edge. That word's vld becomes visible next cycle, so latency is 1 cycle from the 4th byte.
- in_last with lane<3: the byte at lane+1 is 0x80 and the remaining lanes are 0 in that same word. The byte count is latched as the message length. Next state is S_LENHI if this word's index==13, else S_ZERO.
- in_last with lane==3: the word is full; go to S_PAD80.
- S_PAD80: emit 0x80000000. After its transfer, go to S_LENHI if its index==13, else S_ZERO.
- S_ZERO: emit 0x00000000 words. After the transfer at index 13, go to S_LENHI. An index of 14 or 15 on entry therefore wraps through a whole extra block.
- S_LENHI: emit bitlen[63:32]; then S_LENLO.
- S_LENLO: emit bitlen[31:0] with msg_last=1 (and blk_last=1). On its transfer, clear count/widx/lane, deassert busy, and return to S_DATA.
- in_rdy is 0 in every state except S_DATA, so the next message cannot start until the current one has fully drained.
- Pad/length words each load when the output register is empty or draining. Sustained rate is 1 word/cycle with buf_data_rdy held high.
- Byte counter wraps mod 2^LEN_W silently; bit length is then taken from the wrapped count.
- in_vld with in_rdy=0: no effect. The source holds the byte.
- rst_n asserted mid-message or mid-padding: immediate return to the reset state. The partial word and pending output are discarded and buf_data_vld drops asynchronously.

Test Plan:
- "abc" (0x61,0x62,0x63, in_last on 0x63), rdy=1 → 16 words: 0x61626380, 13×0x00000000, 0x00000000, 0x00000018; blk_last and msg_last on word 15 only.
- 55 bytes 0x00..0x36 → 16 words; word13=0x34353680; words14/15=0x00000000/0x000001B8.
- 56 bytes → 32 words; word14=0x80000000, words15..29 zero, word30=0x00000000, word31=0x000001C0; blk_last on words 15 and 31, msg_last on 31 only.
- 64 bytes → 32 words; word16=0x80000000, word31=0x00000200; in_rdy=0 from the cycle after in_last until the word31 transfer.
- Backpressure: "abc" with buf_data_rdy toggling pseudo-randomly → identical word sequence, no loss or duplication, buf_data stable while vld&!rdy.
- Reset mid-message: assert rst_n=0 after 30 bytes of a 100-byte message, then send "abc" → all outputs 0 during reset; post-reset stream exactly equals the "abc" case.
